// File: rtl/ad_nios_cascade_counter_if.sv
// rtl/ad_nios_cascade_counter_if.sv - Nios register-bus interface for the cascade counter
interface ad_nios_cascade_counter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic             read_n;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata, read_n,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata, read_n,
    output readdata
  );
endinterface

// File: rtl/ad_nios_cascade_counter.sv
// rtl/ad_nios_cascade_counter.sv - prescaled down-counter driving lcell cnt_ena/cascout, Nios register port
// Optional capture register for coherent COUNT reads: CASCADE_COUNTER_CAPTURE_EN
module ad_nios_cascade_counter #(
  parameter int WIDTH = 16,
  parameter int PS_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ad_nios_cascade_counter_if.slave      bus,
  input  logic                          count_gate,
  output logic                          cnt_ena,
  output logic                          cascout,
  output logic                          irq
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_HOLD} state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

  state_t            state, state_nxt;
  logic              oneshot, irq_en, tc_flag;
  logic [PS_W-1:0]   divisor, ps_cnt;
  logic [WIDTH-1:0]  reload, count, cap_rd, status, rdata;
  logic              wr, rd, ctrl_wr, count_wr, run_bit, tick, tc;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign rd       = bus.chipselect & ~bus.read_n;
  assign ctrl_wr  = wr && (bus.address == 2'd0);
  assign count_wr = wr && (bus.address == 2'd2);
  assign run_bit  = bus.writedata[0];
  assign irq      = tc_flag & irq_en;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_STOP;
    else          state <= state_nxt;
  end

  // A COUNT write overrides a coincident tick, so it also cancels terminal count.
  always_comb begin
    state_nxt = state;
    tick      = (state == ST_RUN) && count_gate && (ps_cnt == divisor);
    tc        = tick && !count_wr && (count == '0);
    case (state)
      ST_STOP: if (ctrl_wr && run_bit) state_nxt = ST_RUN;
      ST_RUN: begin
        if (ctrl_wr && !run_bit) state_nxt = ST_STOP;
        else if (tc && oneshot)  state_nxt = ST_HOLD;
      end
      ST_HOLD: if (ctrl_wr) state_nxt = run_bit ? ST_RUN : ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
      divisor <= '0;
      tc_flag <= 1'b0;
      reload  <= '0;
      count   <= '0;
      ps_cnt  <= '0;
      cnt_ena <= 1'b0;
      cascout <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        oneshot <= bus.writedata[1];
        irq_en  <= bus.writedata[2];
        divisor <= bus.writedata[4 +: PS_W];
      end
      if (tc)                               tc_flag <= 1'b1;
      else if (ctrl_wr && bus.writedata[3]) tc_flag <= 1'b0;

      if (wr && (bus.address == 2'd1)) reload <= bus.writedata;

      if (count_wr)  count <= bus.writedata;
      else if (tick) count <= (count == '0) ? reload : count - CNT_ONE;

      if (state != ST_RUN) ps_cnt <= '0;
      else if (count_gate) ps_cnt <= tick ? '0 : ps_cnt + PS_ONE;

      cnt_ena <= tick && !count_wr;
      cascout <= tc;
    end
  end

`ifdef CASCADE_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] capture;

  always_ff @(posedge clk) begin
    if (!reset_n)                          capture <= '0;
    else if (rd && (bus.address == 2'd2))  capture <= count;
  end

  assign cap_rd = capture;
`else
  assign cap_rd = '0;
`endif

  always_comb begin
    status              = '0;
    status[0]           = (state != ST_STOP);
    status[1]           = tc_flag;
    status[2]           = irq_en;
    status[4 +: PS_W]   = divisor;
    case (bus.address)
      2'd0:    rdata = status;
      2'd1:    rdata = reload;
      2'd2:    rdata = count;
      default: rdata = cap_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) bus.readdata <= '0;
    else if (rd)  bus.readdata <= rdata;
  end

endmodule
